// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 compressor datapath.
// The carry-save pair type is also used by the 3:2 compressor tree.
package sha256_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CSA_SPLIT = 16;

    typedef struct packed {
        logic [WORD_W-1:0] sum;
        logic [WORD_W-1:0] carry;
    } csa_pair_t;

endpackage

// File: rtl/csa_pipe_stage.sv
// Generic valid/ready register slice. It accepts new data whenever it is
// empty or being drained in the same cycle, so back-to-back flow has no bubble.
module csa_pipe_stage #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Data is kept on drain; only valid_q carries meaning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_valid && in_ready) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/csa_resolver.sv
// Two-stage carry-propagate adder resolving a carry-save pair into one word.
// The carry chain is cut at SPLIT; c_mid carries across the register boundary.
module csa_resolver
    import sha256_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned SPLIT = CSA_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             out_cout
);

    localparam int unsigned HW = WIDTH - SPLIT;

    typedef struct packed {
        logic [SPLIT-1:0] lo;
        logic             c_mid;
        logic [HW-1:0]    hi_s;
        logic [HW-1:0]    hi_c;
    } s1_t;

    localparam int unsigned S1_W = $bits(s1_t);
    localparam int unsigned S2_W = WIDTH + 1;

    logic [SPLIT:0]  lo;
    s1_t             s1_d;
    s1_t             s1_q;
    logic            s1_valid;
    logic            s2_in_ready;
    logic [HW:0]     hi;
    logic [S2_W-1:0] s2_d;
    logic [S2_W-1:0] s2_q;

    always_comb begin
        lo         = {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
        s1_d.lo    = lo[SPLIT-1:0];
        s1_d.c_mid = lo[SPLIT];
        s1_d.hi_s  = in_sum[WIDTH-1:SPLIT];
        s1_d.hi_c  = in_carry[WIDTH-1:SPLIT];
    end

    csa_pipe_stage #(
        .DATA_W (S1_W)
    ) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // Upper half completes here; hi[HW] is the overall carry out.
    always_comb begin
        hi   = {1'b0, s1_q.hi_s} + {1'b0, s1_q.hi_c} + (HW+1)'(s1_q.c_mid);
        s2_d = {hi, s1_q.lo};
    end

    csa_pipe_stage #(
        .DATA_W (S2_W)
    ) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_word = s2_q[WIDTH-1:0];
    assign out_cout = s2_q[WIDTH];

endmodule
